// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: multi-cycle sequencer between the CPU pipeline and the board
// memories. Engine E2 owns RAM2 and arbitrates it between instruction fetch
// and data access. Engine E1 owns RAM1 and the UART, which share one data bus.
// Both engines run concurrently and generate registered active-low strobes.
module mem_bus_ctrl #(
  parameter int RAM_WAIT  = 1,
  parameter int UART_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic [15:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_wdata_i,
  output logic [15:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stall_o,
  output logic        ram1_en_o,
  output logic        ram1_oe_o,
  output logic        ram1_we_o,
  output logic [17:0] ram1_addr_o,
  output logic [15:0] ram1_wdata_o,
  output logic        ram1_drive_o,
  input  logic [15:0] ram1_rdata_i,
  output logic        ram2_en_o,
  output logic        ram2_oe_o,
  output logic        ram2_we_o,
  output logic [17:0] ram2_addr_o,
  output logic [15:0] ram2_wdata_o,
  output logic        ram2_drive_o,
  input  logic [15:0] ram2_rdata_i,
  output logic        uart_rdn_o,
  output logic        uart_wrn_o,
  input  logic        uart_data_ready_i,
  input  logic        uart_tbre_i,
  input  logic        uart_tsre_i
);

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  typedef enum logic [1:0] {E2_IDLE, E2_SETUP, E2_STROBE, E2_DONE} e2_state_t;
  typedef enum logic [2:0] {E1_IDLE, E1_SETUP, E1_WAITTX, E1_STROBE, E1_DONE} e1_state_t;

  e2_state_t   e2_state;
  logic        e2_gnt_mem;
  logic        e2_wr;
  logic [7:0]  e2_cnt;
  logic        e2_mem_ack;
  logic        e2_rd_done;
  logic [15:0] e2_mem_data;
  logic        e2_take_mem;
  logic        e2_take_if;

  e1_state_t   e1_state;
  logic        e1_uart;
  logic        e1_wr;
  logic [7:0]  e1_cnt;
  logic [7:0]  e1_limit;
  logic        e1_mem_ack;
  logic        e1_rd_done;
  logic [15:0] e1_mem_data;

  logic        mem_sel_e2;
  logic        data_req;
  logic        data_to_ram1;
  logic        data_to_ram2;
  logic        addr_is_uart_data;
  logic        addr_is_uart_stat;

  assign data_req          = mem_read_i | mem_write_i;
  assign data_to_ram2      = data_req & ~mem_addr_i[15];
  assign data_to_ram1      = data_req & mem_addr_i[15];
  assign addr_is_uart_data = (mem_addr_i == UART_DATA_ADDR);
  assign addr_is_uart_stat = (mem_addr_i == UART_STAT_ADDR);

  // RAM2 arbitration: data beats fetch; in DONE only the other requester may be accepted
  assign e2_take_mem = data_to_ram2 &
                       ((e2_state == E2_IDLE) | ((e2_state == E2_DONE) & ~e2_gnt_mem));
  assign e2_take_if  = if_req_i & ~e2_take_mem &
                       ((e2_state == E2_IDLE) | ((e2_state == E2_DONE) & e2_gnt_mem));

  assign e1_limit = e1_uart ? 8'(UART_WAIT) : 8'(RAM_WAIT);

  // E2 engine: sequences RAM2 accesses for whichever requester won arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      e2_state     <= E2_IDLE;
      e2_gnt_mem   <= 1'b0;
      e2_wr        <= 1'b0;
      e2_cnt       <= 8'd0;
      e2_mem_ack   <= 1'b0;
      e2_rd_done   <= 1'b0;
      e2_mem_data  <= 16'h0000;
      if_ack_o     <= 1'b0;
      if_data_o    <= 16'h0000;
      ram2_en_o    <= 1'b1;
      ram2_oe_o    <= 1'b1;
      ram2_we_o    <= 1'b1;
      ram2_drive_o <= 1'b0;
      ram2_addr_o  <= 18'd0;
      ram2_wdata_o <= 16'h0000;
    end else begin
      if_ack_o   <= 1'b0;
      e2_mem_ack <= 1'b0;
      e2_rd_done <= 1'b0;
      case (e2_state)
        E2_IDLE, E2_DONE: begin
          ram2_en_o    <= 1'b1;
          ram2_oe_o    <= 1'b1;
          ram2_we_o    <= 1'b1;
          ram2_drive_o <= 1'b0;
          if (e2_take_mem) begin
            e2_gnt_mem   <= 1'b1;
            e2_wr        <= mem_write_i;
            ram2_addr_o  <= {2'b00, mem_addr_i};
            ram2_wdata_o <= mem_wdata_i;
            ram2_drive_o <= mem_write_i;
            ram2_en_o    <= 1'b0;
            e2_state     <= E2_SETUP;
          end else if (e2_take_if) begin
            e2_gnt_mem  <= 1'b0;
            e2_wr       <= 1'b0;
            ram2_addr_o <= {2'b00, if_addr_i};
            ram2_en_o   <= 1'b0;
            e2_state    <= E2_SETUP;
          end else begin
            e2_state <= E2_IDLE;
          end
        end
        E2_SETUP: begin
          e2_cnt <= 8'd0;
          if (e2_wr) ram2_we_o <= 1'b0;
          else       ram2_oe_o <= 1'b0;
          e2_state <= E2_STROBE;
        end
        E2_STROBE: begin
          if (e2_cnt == 8'(RAM_WAIT)) begin
            ram2_en_o    <= 1'b1;
            ram2_oe_o    <= 1'b1;
            ram2_we_o    <= 1'b1;
            ram2_drive_o <= 1'b0;
            if (e2_gnt_mem) begin
              e2_mem_ack <= 1'b1;
              e2_rd_done <= ~e2_wr;
              if (!e2_wr) e2_mem_data <= ram2_rdata_i;
            end else begin
              if_ack_o  <= 1'b1;
              if_data_o <= ram2_rdata_i;
            end
            e2_state <= E2_DONE;
          end else begin
            e2_cnt <= e2_cnt + 8'd1;
          end
        end
        default: e2_state <= E2_IDLE;
      endcase
    end
  end

  // E1 engine: sequences RAM1 and UART accesses on the shared RAM1 data bus
  always_ff @(posedge clk) begin
    if (rst) begin
      e1_state     <= E1_IDLE;
      e1_uart      <= 1'b0;
      e1_wr        <= 1'b0;
      e1_cnt       <= 8'd0;
      e1_mem_ack   <= 1'b0;
      e1_rd_done   <= 1'b0;
      e1_mem_data  <= 16'h0000;
      ram1_en_o    <= 1'b1;
      ram1_oe_o    <= 1'b1;
      ram1_we_o    <= 1'b1;
      ram1_drive_o <= 1'b0;
      ram1_addr_o  <= 18'd0;
      ram1_wdata_o <= 16'h0000;
      uart_rdn_o   <= 1'b1;
      uart_wrn_o   <= 1'b1;
    end else begin
      e1_mem_ack <= 1'b0;
      e1_rd_done <= 1'b0;
      case (e1_state)
        E1_IDLE: begin
          if (data_to_ram1 && addr_is_uart_stat) begin
            e1_mem_ack <= 1'b1;
            e1_rd_done <= ~mem_write_i;
            if (!mem_write_i)
              e1_mem_data <= {14'b0, uart_data_ready_i, uart_tbre_i & uart_tsre_i};
            e1_state <= E1_DONE;
          end else if (data_to_ram1) begin
            e1_uart      <= addr_is_uart_data;
            e1_wr        <= mem_write_i;
            ram1_addr_o  <= {2'b00, mem_addr_i};
            ram1_wdata_o <= mem_wdata_i;
            ram1_drive_o <= mem_write_i;
            ram1_en_o    <= addr_is_uart_data;
            e1_state     <= E1_SETUP;
          end
        end
        E1_SETUP: begin
          e1_cnt <= 8'd0;
          if (e1_uart && e1_wr) begin
            e1_state <= E1_WAITTX;
          end else begin
            if (e1_uart)    uart_rdn_o <= 1'b0;
            else if (e1_wr) ram1_we_o  <= 1'b0;
            else            ram1_oe_o  <= 1'b0;
            e1_state <= E1_STROBE;
          end
        end
        E1_WAITTX: begin
          if (uart_tbre_i && uart_tsre_i) begin
            uart_wrn_o <= 1'b0;
            e1_state   <= E1_STROBE;
          end
        end
        E1_STROBE: begin
          if (e1_cnt == e1_limit) begin
            ram1_en_o    <= 1'b1;
            ram1_oe_o    <= 1'b1;
            ram1_we_o    <= 1'b1;
            ram1_drive_o <= 1'b0;
            uart_rdn_o   <= 1'b1;
            uart_wrn_o   <= 1'b1;
            e1_mem_ack   <= 1'b1;
            e1_rd_done   <= ~e1_wr;
            if (!e1_wr) e1_mem_data <= ram1_rdata_i;
            e1_state <= E1_DONE;
          end else begin
            e1_cnt <= e1_cnt + 8'd1;
          end
        end
        default: e1_state <= E1_IDLE;
      endcase
    end
  end

  // Remember which engine produced the most recent read so the data output holds it
  always_ff @(posedge clk) begin
    if (rst)             mem_sel_e2 <= 1'b0;
    else if (e2_rd_done) mem_sel_e2 <= 1'b1;
    else if (e1_rd_done) mem_sel_e2 <= 1'b0;
  end

  assign mem_ack_o   = e1_mem_ack | e2_mem_ack;
  assign mem_rdata_o = e2_rd_done ? e2_mem_data :
                       e1_rd_done ? e1_mem_data :
                       mem_sel_e2 ? e2_mem_data : e1_mem_data;
  assign stall_o     = (data_req & ~mem_ack_o) | (if_req_i & ~if_ack_o);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed self-checking bench for mem_bus_ctrl with
// RAM_WAIT=1 and UART_WAIT=2. Edge numbers count from the first rising edge
// after a request is raised (edge 1 is the acceptance edge).
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [15:0] if_addr_i = 16'h0000;
  logic [15:0] if_data_o;
  logic        if_ack_o;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [15:0] mem_addr_i = 16'h0000;
  logic [15:0] mem_wdata_i = 16'h0000;
  logic [15:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        stall_o;
  logic        ram1_en_o, ram1_oe_o, ram1_we_o;
  logic [17:0] ram1_addr_o;
  logic [15:0] ram1_wdata_o;
  logic        ram1_drive_o;
  logic [15:0] ram1_rdata_i;
  logic        ram2_en_o, ram2_oe_o, ram2_we_o;
  logic [17:0] ram2_addr_o;
  logic [15:0] ram2_wdata_o;
  logic        ram2_drive_o;
  logic [15:0] ram2_rdata_i;
  logic        uart_rdn_o, uart_wrn_o;
  logic        uart_data_ready_i = 1'b0;
  logic        uart_tbre_i = 1'b1;
  logic        uart_tsre_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  int          res_mem_ack_edge, res_if_ack_edge, res_first_wrn_edge;
  logic [15:0] res_mem_rdata, res_if_data, res_ram1_wdata;
  logic [17:0] res_ram1_addr;
  logic        res_stall_start, res_stall_at_ack;
  int n_r1_en, n_r1_oe, n_r1_we, n_r1_drive, n_r2_oe, n_r2_we, n_rdn, n_wrn, n_overlap;

  mem_bus_ctrl #(.RAM_WAIT(1), .UART_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .stall_o(stall_o),
    .ram1_en_o(ram1_en_o), .ram1_oe_o(ram1_oe_o), .ram1_we_o(ram1_we_o),
    .ram1_addr_o(ram1_addr_o), .ram1_wdata_o(ram1_wdata_o), .ram1_drive_o(ram1_drive_o),
    .ram1_rdata_i(ram1_rdata_i),
    .ram2_en_o(ram2_en_o), .ram2_oe_o(ram2_oe_o), .ram2_we_o(ram2_we_o),
    .ram2_addr_o(ram2_addr_o), .ram2_wdata_o(ram2_wdata_o), .ram2_drive_o(ram2_drive_o),
    .ram2_rdata_i(ram2_rdata_i),
    .uart_rdn_o(uart_rdn_o), .uart_wrn_o(uart_wrn_o),
    .uart_data_ready_i(uart_data_ready_i), .uart_tbre_i(uart_tbre_i), .uart_tsre_i(uart_tsre_i)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Fixed memory contents seen by the two SRAM buses
  assign ram1_rdata_i = 16'h00C3;
  assign ram2_rdata_i = (ram2_addr_o == 18'h00010) ? 16'h1234 :
                        (ram2_addr_o == 18'h00004) ? 16'hAAAA :
                        (ram2_addr_o == 18'h00000) ? 16'h5555 :
                        (ram2_addr_o == 18'h00002) ? 16'h7777 : 16'hDEAD;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Raise the given requests after an edge, then watch a bounded number of edges,
  // dropping each request as soon as its ack is seen and tallying strobe activity.
  task automatic applyStimulus(input logic rd, input logic wr, input logic fetch,
                               input logic [15:0] maddr, input logic [15:0] wdata,
                               input logic [15:0] faddr, input int tbre_edge,
                               input int max_edges);
    res_mem_ack_edge = -1; res_if_ack_edge = -1; res_first_wrn_edge = -1;
    res_mem_rdata = 16'hxxxx; res_if_data = 16'hxxxx;
    res_ram1_addr = 18'h0; res_ram1_wdata = 16'h0; res_stall_at_ack = 1'bx;
    n_r1_en = 0; n_r1_oe = 0; n_r1_we = 0; n_r1_drive = 0;
    n_r2_oe = 0; n_r2_we = 0; n_rdn = 0; n_wrn = 0; n_overlap = 0;
    @(posedge clk); #1;
    mem_read_i  = rd;
    mem_write_i = wr;
    mem_addr_i  = maddr;
    mem_wdata_i = wdata;
    if_req_i    = fetch;
    if_addr_i   = faddr;
    uart_tbre_i = (tbre_edge <= 0);
    #1 res_stall_start = stall_o;
    for (int k = 1; k <= max_edges; k++) begin
      @(posedge clk); #1;
      if (!ram1_en_o)    n_r1_en++;
      if (!ram1_oe_o)    n_r1_oe++;
      if (!ram1_we_o && n_r1_we == 0) begin
        res_ram1_addr  = ram1_addr_o;
        res_ram1_wdata = ram1_wdata_o;
      end
      if (!ram1_we_o)    n_r1_we++;
      if (ram1_drive_o)  n_r1_drive++;
      if (!ram2_oe_o)    n_r2_oe++;
      if (!ram2_we_o)    n_r2_we++;
      if (!uart_rdn_o)   n_rdn++;
      if (!uart_wrn_o)   n_wrn++;
      if (!ram1_we_o && !ram2_oe_o) n_overlap++;
      if (!uart_wrn_o && res_first_wrn_edge < 0) res_first_wrn_edge = k;
      if (mem_ack_o && res_mem_ack_edge < 0) begin
        res_mem_ack_edge = k;
        res_mem_rdata    = mem_rdata_o;
        res_stall_at_ack = stall_o;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
      end
      if (if_ack_o && res_if_ack_edge < 0) begin
        res_if_ack_edge = k;
        res_if_data     = if_data_o;
        if_req_i = 1'b0;
      end
      uart_tbre_i = (k >= tbre_edge);
    end
  endtask

  initial begin
    int ack_seen;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_strobes", {ram1_en_o, ram1_oe_o, ram1_we_o, ram2_en_o, ram2_oe_o,
                                ram2_we_o, uart_rdn_o, uart_wrn_o}, 8'hFF);
    checkOutput("rst_drive", {ram1_drive_o, ram2_drive_o}, 2'b00);
    checkOutput("rst_acks", {mem_ack_o, if_ack_o}, 2'b00);
    checkOutput("rst_data", {mem_rdata_o, if_data_o}, 32'h0);
    checkOutput("rst_stall", stall_o, 1'b0);
    rst = 1'b0;

    // RAM2 read of 0x0010, no fetch
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0, 0, 7);
    checkOutput("t1_stall_start", res_stall_start, 1'b1);
    checkOutput("t1_ack_edge", res_mem_ack_edge, 4);
    checkOutput("t1_rdata", res_mem_rdata, 16'h1234);
    checkOutput("t1_stall_ack", res_stall_at_ack, 1'b0);
    checkOutput("t1_oe_cycles", n_r2_oe, 2);
    checkOutput("t1_we_cycles", n_r2_we, 0);
    checkOutput("t1_ram1_en", n_r1_en, 0);

    // Fetch and RAM2 data read raised together: data wins
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0004, 16'h0, 16'h0000, 0, 11);
    checkOutput("t2_mem_ack_edge", res_mem_ack_edge, 4);
    checkOutput("t2_if_ack_edge", res_if_ack_edge, 8);
    checkOutput("t2_mem_rdata", res_mem_rdata, 16'hAAAA);
    checkOutput("t2_if_data", res_if_data, 16'h5555);
    checkOutput("t2_oe_cycles", n_r2_oe, 4);

    // RAM1 write concurrent with RAM2 fetch
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h9000, 16'hBEEF, 16'h0002, 0, 7);
    checkOutput("t3_mem_ack_edge", res_mem_ack_edge, 4);
    checkOutput("t3_if_ack_edge", res_if_ack_edge, 4);
    checkOutput("t3_overlap", n_overlap, 2);
    checkOutput("t3_r1_we_cycles", n_r1_we, 2);
    checkOutput("t3_r1_drive_cycles", n_r1_drive, 3);
    checkOutput("t3_ram1_addr", res_ram1_addr, 18'h09000);
    checkOutput("t3_ram1_wdata", res_ram1_wdata, 16'hBEEF);
    checkOutput("t3_if_data", res_if_data, 16'h7777);
    checkOutput("t3_rdata_hold", res_mem_rdata, 16'hAAAA);

    // UART data write waiting for the transmitter
    uart_tsre_i = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hBF00, 16'h0041, 16'h0, 5, 12);
    checkOutput("t4_first_wrn_edge", res_first_wrn_edge, 6);
    checkOutput("t4_wrn_cycles", n_wrn, 3);
    checkOutput("t4_ack_edge", res_mem_ack_edge, 9);
    checkOutput("t4_ram1_en", n_r1_en, 0);
    checkOutput("t4_rdn_cycles", n_rdn, 0);

    // UART status read: data_ready=1, tbre=1, tsre=0
    uart_tsre_i       = 1'b0;
    uart_data_ready_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hBF01, 16'h0, 16'h0, 0, 4);
    checkOutput("t5_ack_edge", res_mem_ack_edge, 1);
    checkOutput("t5_rdata", res_mem_rdata, 16'h0002);
    checkOutput("t5_strobes", n_rdn + n_wrn + n_r1_en + n_r1_oe, 0);
    uart_tsre_i       = 1'b1;
    uart_data_ready_i = 1'b0;

    // RAM1 read
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hC000, 16'h0, 16'h0, 0, 7);
    checkOutput("t6_ack_edge", res_mem_ack_edge, 4);
    checkOutput("t6_rdata", res_mem_rdata, 16'h00C3);
    checkOutput("t6_oe_cycles", n_r1_oe, 2);

    // Reset during the strobe of a RAM2 write
    @(posedge clk); #1;
    mem_write_i = 1'b1;
    mem_addr_i  = 16'h0020;
    mem_wdata_i = 16'h5A5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("t7_we_before_rst", ram2_we_o, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t7_strobes", {ram1_en_o, ram1_oe_o, ram1_we_o, ram2_en_o, ram2_oe_o,
                               ram2_we_o, uart_rdn_o, uart_wrn_o}, 8'hFF);
    checkOutput("t7_drive", {ram1_drive_o, ram2_drive_o}, 2'b00);
    checkOutput("t7_ack", mem_ack_o, 1'b0);
    rst = 1'b0;
    mem_write_i = 1'b0;
    ack_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (mem_ack_o) ack_seen = 1;
    end
    checkOutput("t7_no_ack", ack_seen, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0, 0, 7);
    checkOutput("t7_fresh_ack_edge", res_mem_ack_edge, 4);
    checkOutput("t7_fresh_rdata", res_mem_rdata, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Multi-cycle bus sequencer between the CPU pipeline and the board memories: RAM1, RAM2 and the UART, which shares the RAM1 data bus.
- Decodes each request address, arbitrates RAM2 between instruction fetch and MEM-stage data access, and generates the active-low chip strobes with fixed setup/strobe/release timing.
- Returns read data with a one-cycle ack, and drives the pipeline stall.

Parameters:
- RAM_WAIT, 1, extra cycles OE/WE held low on an SRAM access (strobe width = RAM_WAIT+1 cycles).
- UART_WAIT, 2, extra cycles RDN/WRN held low on a UART access (strobe width = UART_WAIT+1 cycles).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_i  in  1  instruction fetch request; level, held until if_ack_o.
- if_addr_i  in  16  fetch address (always RAM2).
- if_data_o  out  16  fetched instruction; valid while if_ack_o is high.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- mem_read_i  in  1  data read request; level, held until mem_ack_o.
- mem_write_i  in  1  data write request; level, held until mem_ack_o.
- mem_addr_i  in  16  data address.
- mem_wdata_i  in  16  write data.
- mem_rdata_o  out  16  read data; valid while mem_ack_o is high.
- mem_ack_o  out  1  one-cycle data completion pulse.
- stall_o  out  1  high while any request is pending and not yet acked.
- ram1_en_o, ram1_oe_o, ram1_we_o  out  1 each  RAM1 strobes, active-low.
- ram1_addr_o  out  18  RAM1 address, {2'b00, addr}.
- ram1_wdata_o  out  16  RAM1/UART bus write value.
- ram1_drive_o  out  1  tristate enable for the RAM1/UART data bus.
- ram1_rdata_i  in  16  RAM1/UART bus read value.
- ram2_en_o, ram2_oe_o, ram2_we_o  out  1 each  RAM2 strobes, active-low.
- ram2_addr_o  out  18  RAM2 address, {2'b00, addr}.
- ram2_wdata_o  out  16  RAM2 bus write value.
- ram2_drive_o  out  1  tristate enable for the RAM2 data bus.
- ram2_rdata_i  in  16  RAM2 bus read value.
- uart_rdn_o, uart_wrn_o  out  1 each  UART read/write strobes, active-low.
- uart_data_ready_i, uart_tbre_i, uart_tsre_i  in  1 each  UART status inputs.

Behaviour:
- Address decode:
  - 0x0000–0x7FFF → RAM2.
  - 0xBF00 → UART data.
  - 0xBF01 → UART status.
  - any other 0x8000–0xFFFF → RAM1.
- Request validity and priority:
  - A data request is mem_read_i|mem_write_i.
  - If both are high, the request is a write.
- Reset:
  - All strobes high (en/oe/we/rdn/wrn = 1), drive_o = 0, acks = 0.
  - Data outputs = 0x0000; both engines in IDLE.
  - A reset asserted mid-access deasserts every strobe on the next edge and abandons the access without an ack.
- Two independent engines:
  - E2 owns RAM2.
  - E1 owns RAM1 and the UART.
  - They run concurrently, so a fetch from RAM2 overlaps a data access to RAM1 or the UART.
- E2 states: IDLE → SETUP → STROBE → DONE → IDLE.
  - IDLE arbitration: a data request to RAM2 beats if_req_i. The loser waits; the requester is latched at acceptance and the grant does not change mid-access.
  - SETUP (1 cycle): address, en=0, wdata and drive (write only) valid.
  - STROBE (RAM_WAIT+1 cycles): oe=0 for a read or we=0 for a write. Read data is captured on the last STROBE edge.
  - DONE (1 cycle): strobes high, en high, drive=0, ack to the granted requester, captured data presented.
  - Access latency from acceptance to ack = RAM_WAIT+3 edges.
  - A request still high in the cycle after its ack is treated as new. Requesters must drop or advance it on the ack edge.
- E1 states: IDLE → SETUP → WAITTX → STROBE → DONE.
  - RAM1 uses the same sequence and timing as E2 and skips WAITTX.
  - UART write: WAITTX holds until uart_tbre_i & uart_tsre_i; then STROBE with wrn=0 for UART_WAIT+1 cycles, drive=1; then DONE.
  - UART data read: STROBE with rdn=0 for UART_WAIT+1 cycles; capture ram1_rdata_i on the last edge; then DONE. No data_ready wait, because software polls 0xBF01.
  - UART status read (0xBF01): IDLE → DONE directly (ack 1 cycle after acceptance). Data = {14'b0, uart_data_ready_i, uart_tbre_i & uart_tsre_i}, sampled at acceptance.
  - A write to 0xBF01: no strobe, ack after 1 cycle.
  - ram1_en_o stays 1 for any UART access.
- Outputs and stall:
  - stall_o = (data_req & ~mem_ack_o) | (if_req_i & ~if_ack_o). It is combinational.
  - The ack pulse is registered and lasts exactly 1 cycle.
  - Data outputs hold their last captured value between acks.

Test Plan:
- RAM_WAIT=1, read of RAM2 0x0010 holding 0x1234, no fetch → ram2_oe_o low for 2 cycles, mem_ack_o on edge 4, mem_rdata_o=0x1234, stall_o falls with the ack.
- Fetch from 0x0000 and data read from 0x0004 raised in the same cycle → data served first (ack edge 4), fetch acked at edge 8; oe never overlaps between the two accesses.
- Write 0xBEEF to 0x9000 concurrent with fetch from 0x0002 → ram1_we_o and ram2_oe_o active in the same cycles; both acks on edge 4; ram1_addr_o=0x09000.
- Write 0x0041 to 0xBF00 with tbre=0 for 5 cycles then 1, tsre=1 → uart_wrn_o stays high during the wait, then low 3 cycles; ack follows; ram1_en_o stays 1.
- Read 0xBF01 with data_ready=1, tbre=1, tsre=0 → ack 1 cycle after acceptance, mem_rdata_o=0x0002, no strobes.
- rst pulsed during the STROBE of a RAM2 write → next edge: all strobes 1, drive 0, no ack; a fresh read afterwards completes normally.
